// File: rtl/ps2_scan_fifo.sv
// PS/2 device-to-host frame receiver with E0/F0 prefix folding into a first-word-fall-through event FIFO.
// Latency: an event is written one clk after the stop bit is accepted and becomes visible one clk after that write.
// Backpressure: none toward the PS/2 device; an event that arrives while the FIFO is full is dropped and sets the sticky overflow flag.
//
// Ports:
//   clk, reset          system clock, asynchronous active-low reset
//   keyb_clk            PS/2 clock (asynchronous to clk)
//   serial_stream       PS/2 data (asynchronous to clk)
//   rd_en               pop the head entry (ignored while valid=0)
//   valid               FIFO holds at least one event
//   code_out            scan code of the head event
//   released            head event is a break (key-up)
//   extended            head event was prefixed by E0
//   count, full         FIFO occupancy
//   overflow            sticky flag: an event was lost because the FIFO was full
//   frame_err           one-cycle pulse on a start, stop, parity or timeout error
module ps2_scan_fifo #(
   parameter int FIFO_DEPTH     = 8,
   parameter int SYNC_STAGES    = 2,
   parameter int TIMEOUT_CYCLES = 2000,
   parameter bit CHECK_PARITY   = 1'b1,
   parameter bit REPORT_BREAK   = 1'b1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          keyb_clk,
   input  logic                          serial_stream,
   input  logic                          rd_en,
   output logic                          valid,
   output logic [7:0]                    code_out,
   output logic                          released,
   output logic                          extended,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          full,
   output logic                          overflow,
   output logic                          frame_err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers and falling-edge detect on keyb_clk
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] r_kclk_sync;
   logic [SYNC_STAGES-1:0] r_data_sync;
   logic                   r_kclk_prev;
   logic                   w_fall;
   logic                   w_bit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_kclk_sync <= '1;
         r_data_sync <= '1;
         r_kclk_prev <= 1'b1;
      end else begin
         r_kclk_sync <= {r_kclk_sync[SYNC_STAGES-2:0], keyb_clk};
         r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], serial_stream};
         r_kclk_prev <= r_kclk_sync[SYNC_STAGES-1];
      end
   end

   assign w_fall = r_kclk_prev & ~r_kclk_sync[SYNC_STAGES-1];
   assign w_bit  = r_data_sync[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Frame FSM
   // ------------------------------------------------------------------
   state_t          r_state;
   state_t          w_state_nxt;
   logic [7:0]      r_shift;
   logic [2:0]      r_bit_cnt;
   logic            r_par;
   logic [TW-1:0]   r_wd;
   logic            r_frame_err;
   logic            r_acc_vld;
   logic [7:0]      r_acc_byte;
   logic            w_err;
   logic            w_accept;
   logic            w_timeout;
   logic            w_par_ok;

   // Odd parity: data ones plus parity bit must be odd.
   assign w_par_ok  = ^{r_shift, r_par};
   // A falling edge on the same cycle resets the watchdog, so it wins.
   assign w_timeout = (r_state != S_IDLE) && !w_fall && (r_wd == TW'(TIMEOUT_CYCLES));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_err       = 1'b0;
      w_accept    = 1'b0;
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
         w_err       = 1'b1;
      end else if (w_fall) begin
         case (r_state)
            S_IDLE: begin
               if (!w_bit) w_state_nxt = S_DATA;
               else        w_err       = 1'b1;
            end
            S_DATA: begin
               if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            end
            S_PARITY: w_state_nxt = S_STOP;
            S_STOP: begin
               w_state_nxt = S_IDLE;
               if (!w_bit || (CHECK_PARITY && !w_par_ok)) w_err    = 1'b1;
               else                                       w_accept = 1'b1;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_shift     <= 8'h00;
         r_bit_cnt   <= 3'd0;
         r_par       <= 1'b0;
         r_wd        <= '0;
         r_frame_err <= 1'b0;
         r_acc_vld   <= 1'b0;
         r_acc_byte  <= 8'h00;
      end else begin
         if (w_fall)                        r_wd <= '0;
         else if (r_wd != TW'(TIMEOUT_CYCLES)) r_wd <= r_wd + TW'(1);

         if (w_fall && r_state == S_IDLE) r_bit_cnt <= 3'd0;
         if (w_fall && r_state == S_DATA) begin
            // LSB arrives first, so shift in from the top.
            r_shift   <= {w_bit, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
         end
         if (w_fall && r_state == S_PARITY) r_par <= w_bit;

         r_frame_err <= w_err;
         r_acc_vld   <= w_accept;
         if (w_accept) r_acc_byte <= r_shift;
      end
   end

   assign frame_err = r_frame_err;

   // ------------------------------------------------------------------
   // Prefix folding: E0/F0 only set flags, any other byte makes an event
   // ------------------------------------------------------------------
   logic       r_ext_pend;
   logic       r_brk_pend;
   logic       w_is_pref;
   logic       w_evt_vld;
   logic [9:0] w_evt;

   assign w_is_pref = (r_acc_byte == 8'hE0) || (r_acc_byte == 8'hF0);
   assign w_evt_vld = r_acc_vld && !w_is_pref && (REPORT_BREAK || !r_brk_pend);
   assign w_evt     = {r_ext_pend, r_brk_pend, r_acc_byte};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_ext_pend <= 1'b0;
         r_brk_pend <= 1'b0;
      end else if (r_acc_vld) begin
         if (r_acc_byte == 8'hE0)      r_ext_pend <= 1'b1;
         else if (r_acc_byte == 8'hF0) r_brk_pend <= 1'b1;
         else begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------
   // FWFT event FIFO
   // ------------------------------------------------------------------
   logic [9:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_overflow;
   logic [9:0]    r_hold;
   logic [9:0]    w_head;
   logic [9:0]    w_out;
   logic          w_pop;
   logic          w_push;

   assign valid  = (r_count != '0);
   assign full   = (r_count == CW'(FIFO_DEPTH));
   assign w_pop  = rd_en & valid;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign w_push = w_evt_vld & (!full | w_pop);

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= w_evt;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
         r_hold     <= 10'h000;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
         if (w_evt_vld && full && !w_pop) r_overflow <= 1'b1;
         // Track the visible head so the outputs freeze once the FIFO empties.
         if (valid) r_hold <= w_head;
      end
   end

   assign w_head   = r_mem[r_rd_ptr];
   assign w_out    = valid ? w_head : r_hold;
   assign extended = w_out[9];
   assign released = w_out[8];
   assign code_out = w_out[7:0];
   assign count    = r_count;
   assign overflow = r_overflow;

endmodule

// File: tb/tb_ps2_scan_fifo.sv
// Self-checking bench for ps2_scan_fifo: three instances (default, break events discarded, parity ignored) share stimulus.
// Latency: events are expected within a PS/2 half-bit period of the stop edge; checks are made at quiescent points.
// Backpressure: reads are issued by the bench; a queue-based reference model predicts contents, overflow and frame errors.
module tb_ps2_scan_fifo;
   localparam int DEPTH = 8;
   localparam int TMO   = 200;
   localparam int HALF  = 8;

   logic       clk = 1'b0;
   logic       reset;
   logic       keyb_clk;
   logic       serial_stream;
   logic       rd_en;
   logic [2:0] valid_v, rel_v, ext_v, full_v, ovf_v, fe_v;
   logic [7:0] code_v  [3];
   logic [3:0] count_v [3];

   int checks   = 0;
   int failures = 0;

   logic [9:0] mq [3][$];
   bit         m_ext [3];
   bit         m_brk [3];
   bit         m_ovf [3];
   int         fe_exp [3];
   int         fe_cnt [3];

   always #5 clk = ~clk;

   ps2_scan_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) u_dut0 (
      .clk(clk), .reset(reset), .keyb_clk(keyb_clk), .serial_stream(serial_stream), .rd_en(rd_en),
      .valid(valid_v[0]), .code_out(code_v[0]), .released(rel_v[0]), .extended(ext_v[0]),
      .count(count_v[0]), .full(full_v[0]), .overflow(ovf_v[0]), .frame_err(fe_v[0]));

   ps2_scan_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .REPORT_BREAK(1'b0)) u_dut1 (
      .clk(clk), .reset(reset), .keyb_clk(keyb_clk), .serial_stream(serial_stream), .rd_en(rd_en),
      .valid(valid_v[1]), .code_out(code_v[1]), .released(rel_v[1]), .extended(ext_v[1]),
      .count(count_v[1]), .full(full_v[1]), .overflow(ovf_v[1]), .frame_err(fe_v[1]));

   ps2_scan_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO), .CHECK_PARITY(1'b0)) u_dut2 (
      .clk(clk), .reset(reset), .keyb_clk(keyb_clk), .serial_stream(serial_stream), .rd_en(rd_en),
      .valid(valid_v[2]), .code_out(code_v[2]), .released(rel_v[2]), .extended(ext_v[2]),
      .count(count_v[2]), .full(full_v[2]), .overflow(ovf_v[2]), .frame_err(fe_v[2]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: one accepted (or rejected) byte for configuration c.
   // c=1 discards break events, c=2 ignores the parity bit.
   task automatic model_byte(input int c, input logic [7:0] b, input bit bad_par);
      logic [9:0] ev;
      if (bad_par && c != 2) begin
         fe_exp[c]++;
         return;
      end
      if (b == 8'hE0) m_ext[c] = 1'b1;
      else if (b == 8'hF0) m_brk[c] = 1'b1;
      else begin
         ev = {m_ext[c], m_brk[c], b};
         m_ext[c] = 1'b0;
         m_brk[c] = 1'b0;
         if (!(ev[8] && c == 1)) begin
            if (mq[c].size() >= DEPTH) m_ovf[c] = 1'b1;
            else                        mq[c].push_back(ev);
         end
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         mq[c].delete();
         m_ext[c] = 1'b0;
         m_brk[c] = 1'b0;
         m_ovf[c] = 1'b0;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit bad_par);
      logic [10:0] bits;
      bits[0]   = 1'b0;
      bits[8:1] = b;
      bits[9]   = ~(^b) ^ bad_par;
      bits[10]  = 1'b1;
      for (int i = 0; i < 11; i++) begin
         serial_stream = bits[i];
         wait_clk(HALF);
         keyb_clk = 1'b0;
         if (i == 10) for (int c = 0; c < 3; c++) model_byte(c, b, bad_par);
         wait_clk(HALF);
         keyb_clk = 1'b1;
      end
      wait_clk(2 * HALF);
   endtask

   // Start bit plus random data bits, leaving keyb_clk high afterwards.
   task automatic send_bits(input int n);
      for (int i = 0; i < n; i++) begin
         serial_stream = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         wait_clk(HALF);
         keyb_clk = 1'b0;
         wait_clk(HALF);
         keyb_clk = 1'b1;
      end
   endtask

   task automatic pop();
      rd_en = 1'b1;
      @(posedge clk);
      #1;
      rd_en = 1'b0;
      wait_clk(2);
   endtask

   task automatic check_state(input string tag);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("%s_count%0d", tag, c), 32'(count_v[c]), 32'(mq[c].size()));
         chk($sformatf("%s_valid%0d", tag, c), 32'(valid_v[c]), 32'(mq[c].size() != 0));
         chk($sformatf("%s_full%0d", tag, c), 32'(full_v[c]), 32'(mq[c].size() == DEPTH));
         chk($sformatf("%s_ovf%0d", tag, c), 32'(ovf_v[c]), 32'(m_ovf[c]));
         chk($sformatf("%s_ferr%0d", tag, c), 32'(fe_cnt[c]), 32'(fe_exp[c]));
         if (mq[c].size() != 0)
            chk($sformatf("%s_head%0d", tag, c), 32'({ext_v[c], rel_v[c], code_v[c]}), 32'(mq[c][0]));
      end
   endtask

   // Monitor: counts frame_err cycles and checks every popped head against the model.
   always @(negedge clk) begin
      for (int c = 0; c < 3; c++) begin
         if (fe_v[c] === 1'b1) fe_cnt[c]++;
         if (rd_en && valid_v[c]) begin
            if (mq[c].size() == 0)
               chk($sformatf("pop_extra%0d", c), 32'(valid_v[c]), 32'd0);
            else begin
               chk($sformatf("pop_head%0d", c), 32'({ext_v[c], rel_v[c], code_v[c]}), 32'(mq[c][0]));
               void'(mq[c].pop_front());
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got running, expected finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [7:0] mk [9];
      logic [7:0] b;
      mk = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

      reset         = 1'b0;
      keyb_clk      = 1'b1;
      serial_stream = 1'b1;
      rd_en         = 1'b0;
      model_reset();
      wait_clk(5);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("rst_valid%0d", c), 32'(valid_v[c]), 32'd0);
         chk($sformatf("rst_count%0d", c), 32'(count_v[c]), 32'd0);
         chk($sformatf("rst_code%0d", c), 32'({ext_v[c], rel_v[c], code_v[c]}), 32'd0);
         chk($sformatf("rst_flags%0d", c), 32'({full_v[c], ovf_v[c], fe_v[c]}), 32'd0);
      end
      reset = 1'b1;
      wait_clk(5);

      // Make, break, make of 0x73
      send_frame(8'h73, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h73, 1'b0);
      chk("tp1_count", 32'(count_v[0]), 32'd2);
      chk("tp1_head", 32'({ext_v[0], rel_v[0], code_v[0]}), 32'h073);
      check_state("tp1");
      pop();
      chk("tp1_head2", 32'({ext_v[0], rel_v[0], code_v[0]}), 32'h173);
      pop();
      chk("tp1_empty", 32'(valid_v[0]), 32'd0);
      check_state("tp1b");

      // Extended make then extended break
      send_frame(8'hE0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk("tp2_ext_make", 32'({ext_v[0], rel_v[0], code_v[0]}), 32'h275);
      check_state("tp2a");
      pop();
      send_frame(8'hE0, 1'b0);
      send_frame(8'hF0, 1'b0);
      send_frame(8'h75, 1'b0);
      chk("tp2_ext_brk", 32'({ext_v[0], rel_v[0], code_v[0]}), 32'h375);
      chk("tp2_nobrk_cnt", 32'(count_v[1]), 32'd0);
      chk("tp2_nobrk_ovf", 32'(ovf_v[1]), 32'd0);
      check_state("tp2b");
      pop();

      // Inverted parity
      send_frame(8'h73, 1'b1);
      chk("tp3_cnt", 32'(count_v[0]), 32'd0);
      chk("tp3_ferr", 32'(fe_cnt[0]), 32'd1);
      chk("tp3_nopar_head", 32'({ext_v[2], rel_v[2], code_v[2]}), 32'h073);
      check_state("tp3");
      pop();

      // Partial frame abandoned by timeout
      send_bits(5);
      wait_clk(TMO + 10);
      for (int c = 0; c < 3; c++) fe_exp[c]++;
      check_state("tp4a");
      send_frame(8'h6B, 1'b0);
      chk("tp4_head", 32'({ext_v[0], rel_v[0], code_v[0]}), 32'h06B);
      check_state("tp4b");
      pop();

      // Streaming with rd_en held high
      rd_en = 1'b1;
      for (int i = 0; i < 6; i++) send_frame(mk[i], 1'b0);
      wait_clk(10);
      rd_en = 1'b0;
      wait_clk(2);
      check_state("tp6");

      // Overflow
      for (int i = 0; i < 9; i++) send_frame(mk[i], 1'b0);
      chk("tp5_full", 32'(full_v[0]), 32'd1);
      chk("tp5_ovf", 32'(ovf_v[0]), 32'd1);
      chk("tp5_count", 32'(count_v[0]), 32'(DEPTH));
      check_state("tp5");
      for (int i = 0; i < DEPTH; i++) pop();
      chk("tp5_empty", 32'(valid_v[0]), 32'd0);
      check_state("tp5b");

      // Reset in the middle of a frame
      send_frame(8'h2E, 1'b0);
      send_bits(5);
      reset = 1'b0;
      #1;
      model_reset();
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("mrst_valid%0d", c), 32'(valid_v[c]), 32'd0);
         chk($sformatf("mrst_count%0d", c), 32'(count_v[c]), 32'd0);
         chk($sformatf("mrst_code%0d", c), 32'({ext_v[c], rel_v[c], code_v[c]}), 32'd0);
         chk($sformatf("mrst_flags%0d", c), 32'({full_v[c], ovf_v[c]}), 32'd0);
      end
      wait_clk(3);
      reset = 1'b1;
      wait_clk(5);
      send_frame(8'h1C, 1'b0);
      chk("mrst_next", 32'({ext_v[0], rel_v[0], code_v[0]}), 32'h01C);
      check_state("mrst");
      pop();

      // Randomised traffic against the model
      for (int it = 0; it < 60; it++) begin
         case ($urandom_range(0, 9))
            0, 1:    b = 8'hE0;
            2, 3:    b = 8'hF0;
            default: b = 8'($urandom_range(0, 255));
         endcase
         send_frame(b, $urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 2)) pop();
         check_state($sformatf("rnd%0d", it));
      end
      for (int i = 0; i < DEPTH; i++) pop();
      check_state("drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_scan_fifo.md
Name: ps2_scan_fifo

Overview:
Parametrised successor to the single-code keyboard reader. It receives PS/2 device-to-host frames on keyb_clk/serial_stream, checks the framing and the odd parity, and folds the E0 (extended) and F0 (break) prefixes into flags. Each completed key event is pushed into a first-word-fall-through FIFO. The calculator and any other consumer drain events at their own pace and no longer need to watch the raw byte stream.

Parameters:
FIFO_DEPTH, 8, number of event entries; power of 2, minimum 2
SYNC_STAGES, 2, flip-flop stages on keyb_clk and serial_stream; minimum 2
TIMEOUT_CYCLES, 2000, clk cycles with no keyb_clk falling edge before a partial frame is dropped
CHECK_PARITY, 1, 1 = a frame with bad odd parity is rejected; 0 = the parity bit is ignored
REPORT_BREAK, 1, 1 = push release events; 0 = release events are discarded silently

Ports:
clk  in  1  system clock; all state is clocked on its rising edge
reset  in  1  asynchronous, active-low reset
keyb_clk  in  1  PS/2 clock, asynchronous to clk
serial_stream  in  1  PS/2 data, asynchronous to clk
rd_en  in  1  pop the head entry; ignored while valid=0
valid  out  1  FIFO not empty
code_out  out  8  scan code at the FIFO head
released  out  1  head entry is a break (key-up) event
extended  out  1  head entry was prefixed by E0
count  out  $clog2(FIFO_DEPTH)+1  current number of entries
full  out  1  count == FIFO_DEPTH
overflow  out  1  sticky; set when an event is dropped because the FIFO is full; cleared only by reset
frame_err  out  1  one-cycle pulse on a start, stop, parity or timeout error

Behaviour:
- Reset (reset=0), asynchronous: FIFO is emptied; valid, count, full, overflow and frame_err = 0; code_out = 0x00; released and extended = 0; all synchroniser stages = 1; FSM goes to IDLE; prefix flags are cleared. A frame in progress is discarded.
- Sampling: both inputs pass through SYNC_STAGES flops. A bit is taken on the clk cycle on which the synchronised keyb_clk is seen to change 1 to 0.
- Frame format: start bit 0, then D0 to D7 (LSB first), then odd parity (the parity bit makes the count of ones across D0..D7 plus parity odd), then stop bit 1.
- FSM states:
  - IDLE: on a falling edge, sample 0 goes to DATA; sample 1 raises frame_err and stays in IDLE.
  - DATA: shift in 8 bits, then go to PARITY.
  - PARITY: latch the parity bit, then go to STOP.
  - STOP: stop bit 0, or parity bad with CHECK_PARITY=1, raises frame_err and returns to IDLE with no byte produced. Otherwise the byte is accepted and the FSM returns to IDLE.
- Timeout: a watchdog counter is cleared on every falling edge. If it reaches TIMEOUT_CYCLES while the FSM is not in IDLE, the FSM returns to IDLE and frame_err pulses. Prefix flags are kept.
- Accepted byte handling:
  - 0xE0 sets ext_pend.
  - 0xF0 sets brk_pend.
  - Any other byte forms the event {ext_pend, brk_pend, byte}, then both flags are cleared.
  - An event with brk_pend=1 and REPORT_BREAK=0 is dropped without setting overflow.
- Push: an event is written 1 cycle after the stop bit is accepted. If the FIFO is full and no pop happens in that same cycle, the event is dropped and overflow is set. A push and a pop in the same cycle on a full FIFO both succeed, and count stays unchanged.
- FWFT read: code_out, released and extended show the head entry combinationally from storage whenever valid=1.
  - rd_en=1 with valid=1 advances the head on that clock edge.
  - An entry written to an empty FIFO appears with valid=1 on the cycle after the write.
  - While valid=0 the outputs hold their last value.
- Pointers wrap modulo FIFO_DEPTH. count is updated in the same cycle as the push or pop.
- frame_err lasts exactly 1 clk cycle for each error.

Test Plan:
- Frame 0x73 (bits 0,1,1,0,0,1,1,1,0,0,1), then F0 (0,0,0,0,0,1,1,1,1,1,1), then 0x73 again; bench does not read -> count=2; head {ext=0,rel=0,0x73}; after one rd_en, head {ext=0,rel=1,0x73}; after a second rd_en, valid=0.
- Frames E0, 75 -> one entry {ext=1,rel=0,0x75}. Then E0, F0, 75 -> entry {ext=1,rel=1,0x75}. REPORT_BREAK=0 variant: the second entry is absent and overflow stays 0.
- Frame 0x73 with its parity bit inverted, CHECK_PARITY=1 -> frame_err pulses once, count stays 0. Repeat with CHECK_PARITY=0 -> entry 0x73 is pushed.
- Five bits of a frame, then keyb_clk held high for TIMEOUT_CYCLES+10 -> frame_err pulses once and the FSM is in IDLE; a following good 0x6B frame is pushed intact.
- Push FIFO_DEPTH+1 make codes (0x16, 0x1E, ...) with no reads -> full=1, overflow=1, count=FIFO_DEPTH; pops return the first FIFO_DEPTH codes in order.
- Hold rd_en=1 while frames stream in -> no entries are lost and overflow=0. Assert reset mid-frame -> all outputs go to their reset values at once; the next complete frame decodes correctly.
